rgmii_idelay_tap_ctrl: RTL and testbench

Sequencer for the RGMII RX input-delay resources: holds IDELAYCTRL in reset, waits for RDY, then loads per-lane tap values into IDELAYE2 primitives configured for VAR_LOAD, one lane at a time. Each load is verified by CNTVALUEOUT readback. Runs on the 200 MHz IDELAY reference clock domain, between the reset synchronizer and the 5 RX delay lanes (rxd[3:0], rx_ctl). Software or a calibration engine retunes taps at runtime through a valid/ready request port.

---
 rtl/rgmii_idelay_tap_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_rgmii_idelay_tap_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_idelay_tap_ctrl.sv
// rgmii_idelay_tap_ctrl
// Brings up the RGMII RX input-delay path: holds IDELAYCTRL in reset, waits
// for RDY, loads init_tap_p into each IDELAYE2 lane (VAR_LOAD) one lane at a
// time, and verifies each load through CNTVALUEOUT readback. Afterwards it
// accepts runtime tap updates through a valid/ready port. Losing RDY restarts
// the whole bring-up; a readback mismatch or RDY timeout parks it in ERROR
// until reset_i.
//
// Ports
//   clk_i, reset_i      200 MHz IDELAY reference clock, sync active-high reset
//   idelayctrl_rst_o    IDELAYCTRL RST
//   idelayctrl_rdy_i    IDELAYCTRL RDY
//   ld_o                per-lane IDELAYE2 LD (one-hot or zero)
//   cntvaluein_o        CNTVALUEIN shared by all lanes
//   cntvalueout_i       CNTVALUEOUT, lane n at [n*tap_width_p +: tap_width_p]
//   cfg_v_i/cfg_lane_i/cfg_tap_i/cfg_ready_o   runtime tap-update request
//   calib_done_o        all lanes loaded and verified, controller idle
//   error_o, err_lane_o sticky error flag and lane of first mismatch
module rgmii_idelay_tap_ctrl #(
    parameter int unsigned lanes_p           = 5,
    parameter int unsigned tap_width_p       = 5,
    parameter int unsigned init_tap_p        = 0,
    parameter int unsigned rst_hold_cycles_p = 16,
    parameter int unsigned settle_cycles_p   = 4,
    parameter int unsigned rdy_timeout_p     = 1024
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    output logic                             idelayctrl_rst_o,
    input  logic                             idelayctrl_rdy_i,
    output logic [lanes_p-1:0]               ld_o,
    output logic [tap_width_p-1:0]           cntvaluein_o,
    input  logic [lanes_p*tap_width_p-1:0]   cntvalueout_i,
    input  logic                             cfg_v_i,
    input  logic [$clog2(lanes_p)-1:0]       cfg_lane_i,
    input  logic [tap_width_p-1:0]           cfg_tap_i,
    output logic                             cfg_ready_o,
    output logic                             calib_done_o,
    output logic                             error_o,
    output logic [$clog2(lanes_p)-1:0]       err_lane_o
);

    localparam int unsigned lane_w_lp     = $clog2(lanes_p);
    localparam int unsigned lane_cmp_w_lp = lane_w_lp + 1;
    localparam int unsigned max_a_lp      = (rst_hold_cycles_p > settle_cycles_p) ?
                                            rst_hold_cycles_p : settle_cycles_p;
    localparam int unsigned max_cnt_lp    = (max_a_lp > rdy_timeout_p) ? max_a_lp : rdy_timeout_p;
    localparam int unsigned cnt_w_lp      = $clog2(max_cnt_lp + 1);

    // ST_INIT_LOAD is a reserved encoding: bring-up loads run through ST_LOAD
    // with init_q set so both paths share the LOAD/SETTLE/CHECK sequence.
    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_INIT_LOAD = 3'd2,
        ST_LOAD      = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_CHECK     = 3'd5,
        ST_IDLE      = 3'd6,
        ST_ERROR     = 3'd7
    } state_e;

    state_e                  state_q, state_d;
    logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic [lane_w_lp-1:0]    lane_q, lane_d;
    logic [tap_width_p-1:0]  tap_q, tap_d;
    logic                    init_q, init_d;
    logic                    rst_q, rst_d;
    logic [lanes_p-1:0]      ld_q, ld_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [lane_w_lp-1:0]    err_lane_q, err_lane_d;

    logic [tap_width_p-1:0]  readback_c;
    logic                    cfg_lane_ok_c;

    // Readback slice of the lane currently being loaded.
    always_comb begin
        readback_c = '0;
        for (int n = 0; n < int'(lanes_p); n++) begin
            if (lane_q == lane_w_lp'(n)) begin
                readback_c = cntvalueout_i[n*tap_width_p +: tap_width_p];
            end
        end
    end

    assign cfg_lane_ok_c = ({1'b0, cfg_lane_i} < lane_cmp_w_lp'(lanes_p));

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        lane_d     = lane_q;
        tap_d      = tap_q;
        init_d     = init_q;
        err_d      = err_q;
        err_lane_d = err_lane_q;

        case (state_q)
            ST_RST_HOLD: begin
                cnt_d = cnt_q + cnt_w_lp'(1);
                if (cnt_q == cnt_w_lp'(rst_hold_cycles_p - 1)) begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                cnt_d = cnt_q + cnt_w_lp'(1);
                if (idelayctrl_rdy_i) begin
                    state_d = ST_LOAD;
                    lane_d  = '0;
                    tap_d   = tap_width_p'(init_tap_p);
                    init_d  = 1'b1;
                end else if (cnt_q == cnt_w_lp'(rdy_timeout_p - 1)) begin
                    state_d    = ST_ERROR;
                    err_d      = 1'b1;
                    err_lane_d = '0;
                end
            end
            ST_LOAD: begin
                if (!idelayctrl_rdy_i) begin
                    state_d = ST_RST_HOLD;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + cnt_w_lp'(1);
                if (!idelayctrl_rdy_i) begin
                    state_d = ST_RST_HOLD;
                end else if (cnt_q == cnt_w_lp'(settle_cycles_p - 1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!idelayctrl_rdy_i) begin
                    state_d = ST_RST_HOLD;
                end else if (readback_c != tap_q) begin
                    state_d    = ST_ERROR;
                    err_d      = 1'b1;
                    err_lane_d = lane_q;
                end else if (init_q && (lane_q != lane_w_lp'(lanes_p - 1))) begin
                    state_d = ST_LOAD;
                    lane_d  = lane_q + lane_w_lp'(1);
                    tap_d   = tap_width_p'(init_tap_p);
                end else begin
                    state_d = ST_IDLE;
                    init_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                if (!idelayctrl_rdy_i) begin
                    state_d = ST_RST_HOLD;
                end else if (cfg_v_i && cfg_lane_ok_c) begin
                    // Out-of-range lanes still handshake but are dropped here.
                    state_d = ST_LOAD;
                    lane_d  = cfg_lane_i;
                    tap_d   = cfg_tap_i;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase

        // Every counter restarts from zero on state entry.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        rst_d   = (state_d == ST_RST_HOLD);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_IDLE);
        for (int n = 0; n < int'(lanes_p); n++) begin
            ld_d[n] = (state_d == ST_LOAD) && (lane_d == lane_w_lp'(n));
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_RST_HOLD;
            cnt_q      <= '0;
            lane_q     <= '0;
            tap_q      <= '0;
            init_q     <= 1'b0;
            rst_q      <= 1'b1;
            ld_q       <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            tap_q      <= tap_d;
            init_q     <= init_d;
            rst_q      <= rst_d;
            ld_q       <= ld_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_lane_q <= err_lane_d;
        end
    end

    assign idelayctrl_rst_o = rst_q;
    assign ld_o             = ld_q;
    assign cntvaluein_o     = tap_q;
    assign cfg_ready_o      = ready_q;
    assign calib_done_o     = done_q;
    assign error_o          = err_q;
    assign err_lane_o       = err_lane_q;

endmodule

// File: tb/tb_rgmii_idelay_tap_ctrl.sv
// Bench for rgmii_idelay_tap_ctrl: IDELAYE2 lanes are modelled as tap
// registers captured on LD, with an optional forced readback on one lane.
module tb_rgmii_idelay_tap_ctrl;

    logic        clk;
    logic        reset_i;
    logic        rst_o;
    logic        rdy;
    logic [4:0]  ld;
    logic [4:0]  cvi;
    logic [24:0] cvo;
    logic        cfg_v;
    logic [2:0]  cfg_lane;
    logic [4:0]  cfg_tap;
    logic        ready;
    logic        done;
    logic        err;
    logic [2:0]  err_lane;

    int checks;
    int errors;

    logic [4:0] model [5];
    logic       force_en;
    logic [2:0] force_lane;
    logic [4:0] force_val;

    rgmii_idelay_tap_ctrl dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .idelayctrl_rst_o (rst_o),
        .idelayctrl_rdy_i (rdy),
        .ld_o             (ld),
        .cntvaluein_o     (cvi),
        .cntvalueout_i    (cvo),
        .cfg_v_i          (cfg_v),
        .cfg_lane_i       (cfg_lane),
        .cfg_tap_i        (cfg_tap),
        .cfg_ready_o      (ready),
        .calib_done_o     (done),
        .error_o          (err),
        .err_lane_o       (err_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IDELAYE2 lane model: tap captured on LD, reset to a non-init value.
    always @(posedge clk) begin
        for (int n = 0; n < 5; n++) begin
            if (reset_i) model[n] <= 5'h1f;
            else if (ld[n]) model[n] <= cvi;
        end
    end

    always_comb begin
        cvo = '0;
        for (int n = 0; n < 5; n++) begin
            cvo[n*5 +: 5] = (force_en && force_lane == 3'(n)) ? force_val : model[n];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts RST cycles from the current cycle, then checks the 5 init loads.
    task automatic run_init(input int rdy_delay);
        int k;
        logic [4:0] exp_ld;
        k = 0;
        while (rst_o === 1'b1 && k < 64) begin
            step();
            k++;
        end
        checks++;
        if (k !== 16) begin
            errors++;
            $display("FAIL rst_hold_len got %0d exp 16", k);
        end
        for (int i = 0; i < rdy_delay; i++) step();
        rdy = 1'b1;
        step();
        for (int n = 0; n < 5; n++) begin
            if (n > 0) repeat (6) step();
            exp_ld = 5'b00001 << n;
            checks++;
            if (ld !== exp_ld || cvi !== 5'd0) begin
                errors++;
                $display("FAIL init_ld lane %0d got ld=%b tap=%0d exp ld=%b tap=0", n, ld, cvi, exp_ld);
            end
        end
        repeat (5) step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL init_done_early got %b exp 0", done);
        end
        step();
        checks++;
        if (done !== 1'b1 || ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL init_done got done=%b ready=%b err=%b exp 1 1 0", done, ready, err);
        end
        checks++;
        if (model[0] !== 5'd0 || model[1] !== 5'd0 || model[2] !== 5'd0 ||
            model[3] !== 5'd0 || model[4] !== 5'd0) begin
            errors++;
            $display("FAIL init_taps got %0d %0d %0d %0d %0d exp all 0",
                     model[0], model[1], model[2], model[3], model[4]);
        end
    endtask

    task automatic test_reset();
        reset_i  = 1'b1;
        rdy      = 1'b0;
        cfg_v    = 1'b0;
        cfg_lane = '0;
        cfg_tap  = '0;
        force_en = 1'b0;
        force_lane = 3'd3;
        force_val  = 5'd8;
        repeat (3) step();
        checks++;
        if (rst_o !== 1'b1 || ld !== 5'd0 || cvi !== 5'd0 || ready !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || err_lane !== 3'd0) begin
            errors++;
            $display("FAIL reset_values got rst=%b ld=%b tap=%0d rdy=%b done=%b err=%b lane=%0d",
                     rst_o, ld, cvi, ready, done, err, err_lane);
        end
        reset_i = 1'b0;
        run_init(10);
    endtask

    task automatic test_update();
        logic [4:0] acc;
        cfg_v = 1'b1; cfg_lane = 3'd2; cfg_tap = 5'd17;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL upd_ready got %b exp 1", ready);
        end
        step();
        cfg_v = 1'b0;
        checks++;
        if (ld !== 5'b00100 || cvi !== 5'd17 || done !== 1'b0) begin
            errors++;
            $display("FAIL upd_load got ld=%b tap=%0d done=%b exp 00100 17 0", ld, cvi, done);
        end
        acc = ld;
        repeat (5) begin
            step();
            acc = acc | ld;
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL upd_done_early got %b exp 0", done);
        end
        step();
        checks++;
        if (done !== 1'b1 || acc !== 5'b00100) begin
            errors++;
            $display("FAIL upd_done got done=%b ld_seen=%b exp 1 00100", done, acc);
        end
        checks++;
        if (model[2] !== 5'd17 || model[0] !== 5'd0 || model[4] !== 5'd0) begin
            errors++;
            $display("FAIL upd_taps got l2=%0d l0=%0d l4=%0d exp 17 0 0", model[2], model[0], model[4]);
        end
    endtask

    task automatic test_bad_lane();
        logic [4:0] acc;
        cfg_v = 1'b1; cfg_lane = 3'd7; cfg_tap = 5'd3;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL badlane_ready got %b exp 1", ready);
        end
        step();
        cfg_v = 1'b0;
        acc = ld;
        repeat (8) begin
            step();
            acc = acc | ld;
        end
        checks++;
        if (acc !== 5'd0 || done !== 1'b1 || cvi !== 5'd17) begin
            errors++;
            $display("FAIL badlane_drop got ld_seen=%b done=%b tap=%0d exp 0 1 17", acc, done, cvi);
        end
    endtask

    task automatic test_rdy_loss();
        cfg_v = 1'b1; cfg_lane = 3'd1; cfg_tap = 5'd4;
        step();
        cfg_v = 1'b0;
        checks++;
        if (ld !== 5'b00010) begin
            errors++;
            $display("FAIL loss_load got %b exp 00010", ld);
        end
        step();
        rdy = 1'b0;
        step();
        checks++;
        if (rst_o !== 1'b1 || done !== 1'b0 || ready !== 1'b0 || ld !== 5'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL loss_restart got rst=%b done=%b ready=%b ld=%b err=%b exp 1 0 0 0 0",
                     rst_o, done, ready, ld, err);
        end
        run_init(0);
    endtask

    task automatic test_reset_mid_load();
        cfg_v = 1'b1; cfg_lane = 3'd0; cfg_tap = 5'd6;
        step();
        cfg_v = 1'b0;
        checks++;
        if (ld !== 5'b00001 || cvi !== 5'd6) begin
            errors++;
            $display("FAIL midload_load got ld=%b tap=%0d exp 00001 6", ld, cvi);
        end
        reset_i = 1'b1;
        step();
        checks++;
        if (rst_o !== 1'b1 || ld !== 5'd0 || cvi !== 5'd0 || ready !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || err_lane !== 3'd0) begin
            errors++;
            $display("FAIL midload_reset got rst=%b ld=%b tap=%0d rdy=%b done=%b err=%b lane=%0d",
                     rst_o, ld, cvi, ready, done, err, err_lane);
        end
        reset_i = 1'b0;
        run_init(0);
    endtask

    task automatic test_readback_error();
        logic seen_ready;
        logic [4:0] acc;
        force_en = 1'b1;
        cfg_v = 1'b1; cfg_lane = 3'd3; cfg_tap = 5'd9;
        step();
        cfg_v = 1'b0;
        checks++;
        if (ld !== 5'b01000 || cvi !== 5'd9) begin
            errors++;
            $display("FAIL rberr_load got ld=%b tap=%0d exp 01000 9", ld, cvi);
        end
        repeat (5) step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL rberr_early got %b exp 0", err);
        end
        step();
        checks++;
        if (err !== 1'b1 || err_lane !== 3'd3 || done !== 1'b0 || ready !== 1'b0 || rst_o !== 1'b0) begin
            errors++;
            $display("FAIL rberr_flag got err=%b lane=%0d done=%b ready=%b rst=%b exp 1 3 0 0 0",
                     err, err_lane, done, ready, rst_o);
        end
        cfg_v = 1'b1; cfg_lane = 3'd0; cfg_tap = 5'd1;
        seen_ready = 1'b0;
        acc = 5'd0;
        repeat (10) begin
            step();
            seen_ready = seen_ready | ready;
            acc = acc | ld;
        end
        cfg_v = 1'b0;
        checks++;
        if (seen_ready !== 1'b0 || acc !== 5'd0 || err !== 1'b1 || err_lane !== 3'd3) begin
            errors++;
            $display("FAIL rberr_stuck got ready_seen=%b ld_seen=%b err=%b lane=%0d exp 0 0 1 3",
                     seen_ready, acc, err, err_lane);
        end
        force_en = 1'b0;
    endtask

    task automatic test_rdy_timeout();
        int k;
        logic seen_ready;
        reset_i = 1'b1;
        rdy = 1'b0;
        step();
        checks++;
        if (err !== 1'b0 || rst_o !== 1'b1) begin
            errors++;
            $display("FAIL tmo_reset got err=%b rst=%b exp 0 1", err, rst_o);
        end
        cfg_v = 1'b1; cfg_lane = 3'd1; cfg_tap = 5'd2;
        reset_i = 1'b0;
        k = 0;
        while (rst_o === 1'b1 && k < 64) begin
            step();
            k++;
        end
        checks++;
        if (k !== 16) begin
            errors++;
            $display("FAIL tmo_rst_hold_len got %0d exp 16", k);
        end
        k = 0;
        seen_ready = 1'b0;
        while (err !== 1'b1 && k < 1100) begin
            step();
            k++;
            seen_ready = seen_ready | ready;
        end
        checks++;
        if (k !== 1024) begin
            errors++;
            $display("FAIL tmo_latency got %0d exp 1024", k);
        end
        checks++;
        if (err_lane !== 3'd0 || seen_ready !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_state got lane=%0d ready_seen=%b ready=%b done=%b exp 0 0 0 0",
                     err_lane, seen_ready, ready, done);
        end
        cfg_v = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_update();
        test_bad_lane();
        test_rdy_loss();
        test_reset_mid_load();
        test_readback_error();
        test_rdy_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end

endmodule
